// File: rtl/packed_line_writer.sv
// packed_line_writer
//
// Sits directly behind the relational-cache packer. Packed 64-byte lines
// arrive on a one-cycle activate pulse and are buffered in a small line FIFO.
// Each buffered line is written to the next destination address as a
// single-beat AXI4 write. A flush request captures the packer's partial
// residual line, writes it with only its valid leading bytes strobed, and
// returns a `consumed` pulse to the packer.
//
// Ports:
//   clock, resetn       system clock, synchronous active-low reset
//   start, dst_base     begin a run at a 64-byte aligned destination
//   line_valid,
//   line_data           packer activate pulse and packed line (MSB byte first)
//   flush, flush_bytes  residual line request and its byte count (0..64)
//   consumed            pulse back to the packer once the residual is taken
//   m_aw*, m_w*, m_b*   AXI4 write master (address, data, response channels)
//   busy, done          run in progress / one-cycle completion pulse
//   lines_written       completed B responses since start (saturating)
//   overflow, error     sticky: line dropped on full FIFO / nonzero bresp
module packed_line_writer #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     dst_base,
   input  logic                      line_valid,
   input  logic [4*DATA_WIDTH-1:0]   line_data,
   input  logic                      flush,
   input  logic [6:0]                flush_bytes,
   output logic                      consumed,
   output logic [ADDR_WIDTH-1:0]     m_awaddr,
   output logic [7:0]                m_awlen,
   output logic [2:0]                m_awsize,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [4*DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/2-1:0]   m_wstrb,
   output logic                      m_wlast,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   input  logic [1:0]                m_bresp,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               lines_written,
   output logic                      overflow,
   output logic                      error
);

   localparam int LW = 4 * DATA_WIDTH;
   localparam int SW = LW / 8;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = LW + SW;
   localparam logic [6:0]            LINE_BYTES  = 7'(SW);
   localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(SW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  done_pend_q, done_pend_d;
   logic [31:0]           lines_q, lines_d;
   logic                  overflow_q, overflow_d;
   logic                  error_q, error_d;
   logic                  consumed_q, consumed_d;
   logic                  flush_pend_q, flush_pend_d;
   logic [6:0]            flush_n_q, flush_n_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];

   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic [EW-1:0] push_entry;
   logic [EW-1:0] head_entry;
   logic [6:0]    flush_n_new, flush_n_eff;
   logic          flush_req, flush_done, flush_enq;
   logic [SW-1:0] flush_strb;
   logic          b_fire;

   // The destination is line aligned, so the low address bits carry nothing.
   logic unused_dst_low;
   assign unused_dst_low = ^dst_base[5:0];

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign head_entry = mem_q[rd_ptr_q];
   assign b_fire     = (state_q == S_B) && m_bvalid;

   // Flush acceptance. A flush that lands together with a full line waits in
   // flush_pend_q until a cycle without line_valid, so the two never compete
   // for the FIFO write port. A nonzero residual also waits for a free slot;
   // the packer keeps presenting the residual on line_data until consumed.
   always_comb begin
      flush_n_new  = (flush_bytes > LINE_BYTES) ? LINE_BYTES : flush_bytes;
      flush_n_eff  = flush_pend_q ? flush_n_q : flush_n_new;
      flush_req    = flush_pend_q || flush;
      flush_done   = flush_req && !line_valid && ((flush_n_eff == 7'd0) || !fifo_full);
      flush_enq    = flush_done && (flush_n_eff != 7'd0);
      flush_strb   = ~({SW{1'b1}} >> flush_n_eff);
      flush_pend_d = flush_pend_q;
      flush_n_d    = flush_n_q;
      if (flush_done) begin
         flush_pend_d = 1'b0;
      end else if (flush && !flush_pend_q) begin
         flush_pend_d = 1'b1;
         flush_n_d    = flush_n_new;
      end
   end

   // Line FIFO bookkeeping. Push sources are exclusive because a flush is
   // never enqueued in a cycle carrying line_valid.
   always_comb begin
      push       = (line_valid && !fifo_full) || flush_enq;
      pop        = (state_q == S_W) && m_wready;
      push_entry = line_valid ? {line_data, {SW{1'b1}}} : {line_data, flush_strb};
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
   end

   // Write FSM next state. From B it returns straight to AW when another
   // line is waiting, which keeps a zero-wait slave at three cycles per line.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (busy_q && !fifo_empty) state_d = S_AW;
         S_AW:   if (m_awready)             state_d = S_W;
         S_W:    if (m_wready)              state_d = S_B;
         S_B: begin
            if (m_bvalid) begin
               state_d = (busy_q && !fifo_empty) ? S_AW : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // AXI outputs follow the state directly, so valids hold until handshake.
   always_comb begin
      m_awaddr  = addr_q;
      m_awlen   = 8'd0;
      m_awsize  = 3'd6;
      m_awvalid = (state_q == S_AW);
      m_wvalid  = (state_q == S_W);
      m_wlast   = (state_q == S_W);
      m_bready  = (state_q == S_B);
      m_wdata   = (state_q == S_W) ? head_entry[SW +: LW] : '0;
      m_wstrb   = (state_q == S_W) ? head_entry[SW-1:0]  : '0;
   end

   // Run control, address advance, counters and sticky flags. done is only
   // raised while busy, and clearing busy with it prevents a second pulse.
   always_comb begin
      busy_d      = busy_q;
      addr_d      = addr_q;
      lines_d     = lines_q;
      overflow_d  = overflow_q;
      error_d     = error_q;
      done_pend_d = done_pend_q;
      done_d      = 1'b0;
      consumed_d  = flush_enq;
      if (start && !busy_q) begin
         busy_d     = 1'b1;
         addr_d     = {dst_base[ADDR_WIDTH-1:6], 6'b0};
         lines_d    = '0;
         overflow_d = 1'b0;
         error_d    = 1'b0;
      end
      if (line_valid && fifo_full) begin
         overflow_d = 1'b1;
      end
      if (b_fire) begin
         addr_d = addr_q + LINE_STRIDE;
         if (lines_q != 32'hFFFF_FFFF) begin
            lines_d = lines_q + 32'd1;
         end
         if (m_bresp != 2'b00) begin
            error_d = 1'b1;
         end
      end
      if (busy_q && done_pend_q && fifo_empty && (state_q == S_IDLE)) begin
         done_d      = 1'b1;
         busy_d      = 1'b0;
         done_pend_d = 1'b0;
      end
      if (flush_done) begin
         done_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_pend_q  <= 1'b0;
         lines_q      <= '0;
         overflow_q   <= 1'b0;
         error_q      <= 1'b0;
         consumed_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         flush_n_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         done_pend_q  <= done_pend_d;
         lines_q      <= lines_d;
         overflow_q   <= overflow_d;
         error_q      <= error_d;
         consumed_q   <= consumed_d;
         flush_pend_q <= flush_pend_d;
         flush_n_q    <= flush_n_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: emptiness is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign lines_written = lines_q;
   assign overflow      = overflow_q;
   assign error         = error_q;
   assign consumed      = consumed_q;

endmodule

// File: tb/tb_packed_line_writer.sv
// Testbench for packed_line_writer: directed scenarios with a reactive AXI
// slave and a scoreboard of expected writes (address, data, strobe) that a
// monitor compares on every W handshake.
module tb_packed_line_writer;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int LW = 512;
   localparam int SW = 64;

   localparam logic [LW-1:0] PAT_A = {16{32'hA1A2_0001}};
   localparam logic [LW-1:0] PAT_B = {16{32'hB1B2_0002}};
   localparam logic [LW-1:0] PAT_C = {16{32'hC1C2_0003}};
   localparam logic [LW-1:0] PAT_D = {16{32'hD1D2_0004}};
   localparam logic [LW-1:0] PAT_E = {16{32'hE1E2_0005}};
   localparam logic [LW-1:0] PAT_F = {16{32'hF1F2_0006}};
   localparam logic [LW-1:0] PAT_R = {16{32'h5E51_D0AA}};
   localparam logic [SW-1:0] STRB_ALL  = {SW{1'b1}};
   localparam logic [SW-1:0] STRB_TOP20 = 64'hFFFF_F000_0000_0000;

   logic          clock;
   logic          resetn;
   logic          start;
   logic [AW-1:0] dst_base;
   logic          line_valid;
   logic [LW-1:0] line_data;
   logic          flush;
   logic [6:0]    flush_bytes;
   logic          consumed;
   logic [AW-1:0] m_awaddr;
   logic [7:0]    m_awlen;
   logic [2:0]    m_awsize;
   logic          m_awvalid;
   logic          m_awready;
   logic [LW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic          m_wlast;
   logic          m_wvalid;
   logic          m_wready;
   logic [1:0]    m_bresp;
   logic          m_bvalid;
   logic          m_bready;
   logic          busy;
   logic          done;
   logic [31:0]   lines_written;
   logic          overflow;
   logic          error;

   typedef struct {
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      logic [SW-1:0] strb;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] aw_q[$];

   int total;
   int bad;
   int consumed_cnt;
   int done_cnt;
   int wcount;
   int err_idx;
   bit w_hs_seen;
   bit b_hs_seen;

   packed_line_writer #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .FIFO_DEPTH(4)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .start         (start),
      .dst_base      (dst_base),
      .line_valid    (line_valid),
      .line_data     (line_data),
      .flush         (flush),
      .flush_bytes   (flush_bytes),
      .consumed      (consumed),
      .m_awaddr      (m_awaddr),
      .m_awlen       (m_awlen),
      .m_awsize      (m_awsize),
      .m_awvalid     (m_awvalid),
      .m_awready     (m_awready),
      .m_wdata       (m_wdata),
      .m_wstrb       (m_wstrb),
      .m_wlast       (m_wlast),
      .m_wvalid      (m_wvalid),
      .m_wready      (m_wready),
      .m_bresp       (m_bresp),
      .m_bvalid      (m_bvalid),
      .m_bready      (m_bready),
      .busy          (busy),
      .done          (done),
      .lines_written (lines_written),
      .overflow      (overflow),
      .error         (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic expectWrite(input logic [AW-1:0] addr, input logic [LW-1:0] data, input logic [SW-1:0] strb);
      exp_t e;
      e.addr = addr;
      e.data = data;
      e.strb = strb;
      exp_q.push_back(e);
   endtask

   // Drives one cycle of stimulus, starting just after a rising edge.
   task automatic applyStimulus(input bit do_start, input logic [AW-1:0] base, input bit do_line,
                                input bit do_flush, input logic [6:0] nbytes, input logic [LW-1:0] data);
      start       = do_start;
      dst_base    = base;
      line_valid  = do_line;
      flush       = do_flush;
      flush_bytes = nbytes;
      line_data   = data;
      @(posedge clock);
      #1;
      start      = 1'b0;
      line_valid = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Resets the DUT; ready lines are only changed after the reset edge so a
   // stalled W beat cannot complete on the way in.
   task automatic doReset();
      resetn      = 1'b0;
      start       = 1'b0;
      line_valid  = 1'b0;
      flush       = 1'b0;
      flush_bytes = 7'd0;
      dst_base    = '0;
      line_data   = '0;
      @(posedge clock);
      #1;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      exp_q.delete();
      aw_q.delete();
      wcount       = 0;
      err_idx      = -1;
      consumed_cnt = 0;
      done_cnt     = 0;
      @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic waitLines(input string name, input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (lines_written == 32'(n)) break;
         @(posedge clock);
         #1;
      end
      checkOutput(name, lines_written, n);
   endtask

   task automatic waitDone(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) break;
         @(posedge clock);
         #1;
      end
      checkOutput(name, done_cnt, 1);
   endtask

   // Monitor: records AW handshakes and scores each W handshake against the
   // oldest expected write. Runs on the falling edge, away from the DUT edge.
   task automatic monitorStep();
      exp_t          e;
      logic [AW-1:0] a;
      if (m_awvalid && m_awready) begin
         aw_q.push_back(m_awaddr);
         checkOutput("awlen", m_awlen, 0);
         checkOutput("awsize", m_awsize, 6);
      end
      if (m_wvalid && m_wready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_write: got data %0h, required no write", m_wdata);
         end else if (aw_q.size() == 0) begin
            total++;
            bad++;
            void'(exp_q.pop_front());
            $display("[TB] FAIL w_without_aw: got W beat with no prior AW, required AW first");
         end else begin
            e = exp_q.pop_front();
            a = aw_q.pop_front();
            checkOutput("awaddr", a, e.addr);
            checkOutput("wdata", m_wdata, e.data);
            checkOutput("wstrb", m_wstrb, e.strb);
            checkOutput("wlast", m_wlast, 1);
         end
      end
      w_hs_seen = m_wvalid && m_wready;
      b_hs_seen = m_bvalid && m_bready;
      if (consumed) consumed_cnt++;
      if (done) done_cnt++;
   endtask

   // Slave B channel: answers one cycle after each W handshake.
   task automatic slaveStep();
      if (!resetn) begin
         m_bvalid = 1'b0;
         m_bresp  = 2'b00;
      end else begin
         if (b_hs_seen) begin
            m_bvalid = 1'b0;
            m_bresp  = 2'b00;
         end
         if (w_hs_seen) begin
            m_bvalid = 1'b1;
            m_bresp  = (wcount == err_idx) ? 2'b10 : 2'b00;
            wcount++;
         end
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      m_awready = 1'b1;
      m_wready  = 1'b1;
      m_bvalid  = 1'b0;
      m_bresp   = 2'b00;
      w_hs_seen = 1'b0;
      b_hs_seen = 1'b0;

      fork
         forever begin
            @(negedge clock);
            monitorStep();
         end
         forever begin
            @(posedge clock);
            #1;
            slaveStep();
         end
      join_none

      // Reset state and three back-to-back lines with a zero-wait slave.
      doReset();
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_awvalid", m_awvalid, 0);
      checkOutput("rst_wvalid", m_wvalid, 0);
      checkOutput("rst_bready", m_bready, 0);
      checkOutput("rst_awaddr", m_awaddr, 0);
      checkOutput("rst_lines", lines_written, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_consumed", consumed, 0);
      expectWrite(32'h1000, PAT_A, STRB_ALL);
      expectWrite(32'h1040, PAT_B, STRB_ALL);
      expectWrite(32'h1080, PAT_C, STRB_ALL);
      applyStimulus(1, 32'h1000, 0, 0, 0, '0);
      checkOutput("t1_busy", busy, 1);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_A);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_B);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_C);
      waitLines("t1_lines", 3, 100);
      idleCycles(10);
      checkOutput("t1_overflow", overflow, 0);
      checkOutput("t1_error", error, 0);
      checkOutput("t1_pending", exp_q.size(), 0);

      // FIFO fill: address channel stalled, six lines into four entries.
      doReset();
      m_awready = 1'b0;
      applyStimulus(1, 32'h2000, 0, 0, 0, '0);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_A);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_B);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_C);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_D);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_E);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_F);
      idleCycles(3);
      checkOutput("t2_overflow", overflow, 1);
      checkOutput("t2_aw_held", m_awvalid, 1);
      checkOutput("t2_lines_stalled", lines_written, 0);
      expectWrite(32'h2000, PAT_A, STRB_ALL);
      expectWrite(32'h2040, PAT_B, STRB_ALL);
      expectWrite(32'h2080, PAT_C, STRB_ALL);
      expectWrite(32'h20C0, PAT_D, STRB_ALL);
      m_awready = 1'b1;
      waitLines("t2_lines", 4, 200);
      idleCycles(20);
      checkOutput("t2_lines_final", lines_written, 4);
      checkOutput("t2_pending", exp_q.size(), 0);

      // Flush of a 20-byte residual after one full line.
      doReset();
      expectWrite(32'h4000, PAT_A, STRB_ALL);
      expectWrite(32'h4040, PAT_R, STRB_TOP20);
      applyStimulus(1, 32'h4000, 0, 0, 0, '0);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_A);
      applyStimulus(0, 32'h0, 0, 1, 7'd20, PAT_R);
      checkOutput("t3_consumed_now", consumed, 1);
      waitDone("t3_done", 100);
      checkOutput("t3_lines", lines_written, 2);
      checkOutput("t3_busy", busy, 0);
      idleCycles(5);
      checkOutput("t3_consumed_cnt", consumed_cnt, 1);
      checkOutput("t3_done_cnt", done_cnt, 1);
      checkOutput("t3_pending", exp_q.size(), 0);

      // Empty flush with nothing buffered: done only, no traffic.
      doReset();
      applyStimulus(1, 32'h5000, 0, 0, 0, '0);
      applyStimulus(0, 32'h0, 0, 1, 7'd0, PAT_R);
      waitDone("t4_done", 3);
      idleCycles(5);
      checkOutput("t4_busy", busy, 0);
      checkOutput("t4_consumed_cnt", consumed_cnt, 0);
      checkOutput("t4_lines", lines_written, 0);
      checkOutput("t4_aw_seen", aw_q.size(), 0);

      // Error response on the second of three writes.
      doReset();
      err_idx = 1;
      expectWrite(32'h6000, PAT_A, STRB_ALL);
      expectWrite(32'h6040, PAT_B, STRB_ALL);
      expectWrite(32'h6080, PAT_C, STRB_ALL);
      applyStimulus(1, 32'h6000, 0, 0, 0, '0);
      checkOutput("t5_error_start", error, 0);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_A);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_B);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_C);
      waitLines("t5_lines", 3, 100);
      idleCycles(5);
      checkOutput("t5_error", error, 1);
      checkOutput("t5_pending", exp_q.size(), 0);

      // Reset while the W beat is stalled, then a fresh run elsewhere.
      doReset();
      m_wready = 1'b0;
      applyStimulus(1, 32'h7000, 0, 0, 0, '0);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_E);
      for (int i = 0; i < 20; i++) begin
         if (m_wvalid) break;
         @(posedge clock);
         #1;
      end
      checkOutput("t6_in_w", m_wvalid, 1);
      resetn = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("t6_awvalid", m_awvalid, 0);
      checkOutput("t6_wvalid", m_wvalid, 0);
      checkOutput("t6_busy", busy, 0);
      doReset();
      expectWrite(32'h8000, PAT_D, STRB_ALL);
      applyStimulus(1, 32'h8000, 0, 0, 0, '0);
      applyStimulus(0, 32'h0, 1, 0, 0, PAT_D);
      waitLines("t6_lines", 1, 100);
      idleCycles(10);
      checkOutput("t6_lines_final", lines_written, 1);
      checkOutput("t6_pending", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
